// File: rtl/tx_pts_ctrl_if.sv
// tx_pts_ctrl_if: handshake and shift-register control bundle for tx_pts_ctrl.
//   tx_data/tx_valid/tx_ready : word handshake from the byte source
//   sr_load/sr_shift/sr_data  : control and parallel data toward flex_pts_sr
//   tx_busy/frame_done        : frame status
// master = byte source / observer side, slave = controller side.
interface tx_pts_ctrl_if #(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned SR_BITS   = 10
);
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic                 sr_load;
  logic                 sr_shift;
  logic [SR_BITS-1:0]   sr_data;
  logic                 tx_busy;
  logic                 frame_done;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, sr_load, sr_shift, sr_data, tx_busy, frame_done
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, sr_load, sr_shift, sr_data, tx_busy, frame_done
  );
endinterface

// File: rtl/tx_pts_ctrl.sv
// tx_pts_ctrl: frame sequencer driving an LSB-first parallel-to-serial shift register.
// Accepts one word per valid/ready handshake, loads {stop,[parity],data,start} into the SR,
// then issues one shift every BIT_PERIOD clocks until the last stop bit has been held.
// Ports:
//   i_clk   : system clock, rising edge
//   i_rst   : asynchronous active-high reset
//   io_bus  : tx_pts_ctrl_if.slave (tx_data/tx_valid in; tx_ready, sr_load, sr_shift,
//             sr_data, tx_busy, frame_done out)
module tx_pts_ctrl #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned BIT_PERIOD = 10,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned PARITY_EN  = 0
) (
  input  logic         i_clk,
  input  logic         i_rst,
  tx_pts_ctrl_if.slave io_bus
);

  localparam int unsigned SrBits = DATA_BITS + PARITY_EN + 2;
  // Index of the final stop bit; the start bit is index 0.
  localparam int unsigned Last   = DATA_BITS + PARITY_EN + STOP_BITS;
  localparam int unsigned TimerW = $clog2(BIT_PERIOD);
  localparam int unsigned CntW   = $clog2(Last + 1);

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  state_e            r_state;
  state_e            w_state_d;
  logic [TimerW-1:0] r_timer;
  logic [TimerW-1:0] w_timer_d;
  logic [CntW-1:0]   r_bit_cnt;
  logic [CntW-1:0]   w_bit_cnt_d;

  logic              w_tx_ready;
  logic              w_tx_busy;
  logic              w_sr_load;
  logic              w_sr_shift;
  logic              w_frame_done;
  logic [SrBits-1:0] w_sr_data;

  // Only one stop bit is loaded; further stop bits come from the SR's 1-fill on shift.
  if (PARITY_EN != 0) begin : g_parity
    assign w_sr_data = {1'b1, ^io_bus.tx_data, io_bus.tx_data, 1'b0};
  end else begin : g_no_parity
    assign w_sr_data = {1'b1, io_bus.tx_data, 1'b0};
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= StIdle;
      r_timer   <= '0;
      r_bit_cnt <= '0;
    end else begin
      r_state   <= w_state_d;
      r_timer   <= w_timer_d;
      r_bit_cnt <= w_bit_cnt_d;
    end
  end

  always_comb begin
    w_state_d    = r_state;
    w_timer_d    = r_timer;
    w_bit_cnt_d  = r_bit_cnt;
    w_tx_ready   = 1'b0;
    w_tx_busy    = 1'b0;
    w_sr_load    = 1'b0;
    w_sr_shift   = 1'b0;
    w_frame_done = 1'b0;
    unique case (r_state)
      StIdle: begin
        w_tx_ready = 1'b1;
        if (io_bus.tx_valid) begin
          w_sr_load   = 1'b1;
          w_state_d   = StSend;
          w_timer_d   = '0;
          w_bit_cnt_d = '0;
        end
      end
      StSend: begin
        w_tx_busy = 1'b1;
        if (r_timer == TimerW'(BIT_PERIOD - 1)) begin
          w_timer_d = '0;
          if (r_bit_cnt == CntW'(Last)) begin
            // Final stop bit has been held a full period; no shift needed.
            w_frame_done = 1'b1;
            w_state_d    = StIdle;
          end else begin
            w_sr_shift  = 1'b1;
            w_bit_cnt_d = r_bit_cnt + 1'b1;
          end
        end else begin
          w_timer_d = r_timer + 1'b1;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  assign io_bus.tx_ready   = w_tx_ready;
  assign io_bus.tx_busy    = w_tx_busy;
  assign io_bus.sr_load    = w_sr_load;
  assign io_bus.sr_shift   = w_sr_shift;
  assign io_bus.frame_done = w_frame_done;
  assign io_bus.sr_data    = w_sr_data;

endmodule

// File: tb/tb_tx_pts_ctrl.sv
// Testbench for tx_pts_ctrl: three instances (plain 8N1, even parity, two stop bits), each
// feeding a behavioural LSB-first shift register with 1-fill whose bit 0 is the line.
module tb_tx_pts_ctrl;
  localparam int BP = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       valid = 1'b0;
  logic [7:0] data = 8'h00;
  int         sel = 0;
  int         errors = 0;
  int         checks = 0;

  always #5 clk = ~clk;

  tx_pts_ctrl_if #(.DATA_BITS(8), .SR_BITS(10)) if_a ();
  tx_pts_ctrl_if #(.DATA_BITS(8), .SR_BITS(11)) if_b ();
  tx_pts_ctrl_if #(.DATA_BITS(8), .SR_BITS(10)) if_c ();

  tx_pts_ctrl #(.DATA_BITS(8), .BIT_PERIOD(BP), .STOP_BITS(1), .PARITY_EN(0)) dut_a (
    .i_clk(clk), .i_rst(rst), .io_bus(if_a));
  tx_pts_ctrl #(.DATA_BITS(8), .BIT_PERIOD(BP), .STOP_BITS(1), .PARITY_EN(1)) dut_b (
    .i_clk(clk), .i_rst(rst), .io_bus(if_b));
  tx_pts_ctrl #(.DATA_BITS(8), .BIT_PERIOD(BP), .STOP_BITS(2), .PARITY_EN(0)) dut_c (
    .i_clk(clk), .i_rst(rst), .io_bus(if_c));

  assign if_a.tx_data  = data;
  assign if_b.tx_data  = data;
  assign if_c.tx_data  = data;
  assign if_a.tx_valid = valid && (sel == 0);
  assign if_b.tx_valid = valid && (sel == 1);
  assign if_c.tx_valid = valid && (sel == 2);

  logic [9:0]  sr_a;
  logic [10:0] sr_b;
  logic [9:0]  sr_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_a <= '1;
      sr_b <= '1;
      sr_c <= '1;
    end else begin
      if (if_a.sr_load) sr_a <= if_a.sr_data;
      else if (if_a.sr_shift) sr_a <= {1'b1, sr_a[9:1]};
      if (if_b.sr_load) sr_b <= if_b.sr_data;
      else if (if_b.sr_shift) sr_b <= {1'b1, sr_b[10:1]};
      if (if_c.sr_load) sr_c <= if_c.sr_data;
      else if (if_c.sr_shift) sr_c <= {1'b1, sr_c[9:1]};
    end
  end

  logic line, ready, busy, load, shift, done;
  always_comb begin
    line = sr_c[0]; ready = if_c.tx_ready; busy = if_c.tx_busy;
    load = if_c.sr_load; shift = if_c.sr_shift; done = if_c.frame_done;
    case (sel)
      0: begin
        line = sr_a[0]; ready = if_a.tx_ready; busy = if_a.tx_busy;
        load = if_a.sr_load; shift = if_a.sr_shift; done = if_a.frame_done;
      end
      1: begin
        line = sr_b[0]; ready = if_b.tx_ready; busy = if_b.tx_busy;
        load = if_b.sr_load; shift = if_b.sr_shift; done = if_b.frame_done;
      end
      default: ;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Starts at a negedge, handshakes one word, follows the frame sample by sample and ends at the
  // negedge of the idle cycle that follows frame_done. exp_bits[k] is line bit k (start = 0).
  task automatic send_frame(input string tag, input logic [7:0] d, input logic [15:0] exp_bits,
                            input int nb, input bit hold, input bit toggle);
    int bad_line = 0;
    int bad_ctl  = 0;
    int nsh      = 0;
    int done_at  = -1;
    data  = d;
    valid = 1'b1;
    #1;
    check({tag, ":hs_ready"}, 32'(ready), 32'd1);
    check({tag, ":hs_load"}, 32'(load), 32'd1);
    check({tag, ":hs_line"}, 32'(line), 32'd1);
    @(posedge clk);
    for (int k = 0; k < nb * BP; k++) begin
      @(negedge clk);
      if (line !== exp_bits[k / BP]) bad_line++;
      if (busy !== 1'b1 || ready !== 1'b0 || load !== 1'b0) bad_ctl++;
      if (shift === 1'b1 && done === 1'b1) bad_ctl++;
      if (shift === 1'b1) nsh++;
      if (done === 1'b1 && done_at < 0) done_at = k;
      if (toggle && k < nb * BP - 1) begin
        valid = 1'($urandom_range(0, 1));
        data  = 8'($urandom);
      end else if (!hold) begin
        valid = 1'b0;
      end
    end
    check({tag, ":line_bits"}, 32'(bad_line), 32'd0);
    check({tag, ":send_ctl"}, 32'(bad_ctl), 32'd0);
    check({tag, ":shifts"}, 32'(nsh), 32'(nb - 1));
    check({tag, ":done_at"}, 32'(done_at), 32'(nb * BP - 1));
    @(negedge clk);
    check({tag, ":idle_ready"}, 32'(ready), 32'd1);
    check({tag, ":idle_busy"}, 32'(busy), 32'd0);
    check({tag, ":idle_line"}, 32'(line), 32'd1);
    check({tag, ":idle_done"}, 32'(done), 32'd0);
    check({tag, ":idle_load"}, 32'(load), 32'(hold));
  endtask

  initial begin
    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_load", 32'(load), 32'd0);
    check("rst_shift", 32'(shift), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_line", 32'(line), 32'd1);
    rst = 1'b0;
    @(negedge clk);

    // 8N1, 0xA5: line 0,1,0,1,0,0,1,0,1,1 -> {1,A5,0} = 10'h34A.
    send_frame("a5", 8'hA5, 16'h034A, 10, 1'b0, 1'b0);

    // Reset in the middle of a frame.
    data  = 8'h81;
    valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    repeat (35) @(negedge clk);
    check("mid_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_ready", 32'(ready), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_shift", 32'(shift), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_line", 32'(line), 32'd1);
    @(negedge clk);
    check("mid_rst_done2", 32'(done), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Back-to-back with tx_valid held: {1,00,0} = 10'h200, {1,FF,0} = 10'h3FE.
    send_frame("b2b_00", 8'h00, 16'h0200, 10, 1'b1, 1'b0);
    send_frame("b2b_ff", 8'hFF, 16'h03FE, 10, 1'b0, 1'b0);

    // tx_valid/tx_data churning during SEND: {1,3C,0} = 10'h278.
    send_frame("tog_3c", 8'h3C, 16'h0278, 10, 1'b0, 1'b1);

    // Even parity: 0x07 -> parity 1 -> 11'h60E; 0x03 -> parity 0 -> 11'h406.
    sel = 1;
    send_frame("par_07", 8'h07, 16'h060E, 11, 1'b0, 1'b0);
    send_frame("par_03", 8'h03, 16'h0406, 11, 1'b0, 1'b0);

    // Two stop bits: {1,1,5A,0} = 11'h6B4, 10 shifts, done at sample 109.
    sel = 2;
    send_frame("stop2_5a", 8'h5A, 16'h06B4, 11, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
